// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared phase encoding and default constants for the game sequencer
//
// Purpose: phase_t encoding seen on the phase output, default flash/game-over
//          colours and the default frame counts used by game_phase_controller.
// Ports:   none (package).
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    HIT       = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4,
    PAUSED    = 3'd5
  } phase_t;

  localparam logic [7:0] DEF_HIT_COLOR      = 8'b11100000;
  localparam logic [7:0] DEF_LEVEL_COLOR    = 8'b00011100;
  localparam logic [7:0] DEF_GAMEOVER_COLOR = 8'b01000000;

  localparam int DEF_FLASH_FRAMES    = 30;
  localparam int DEF_FLASH_PERIOD    = 6;
  localparam int DEF_GAMEOVER_FRAMES = 120;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - video-frame counter with terminal-count detect
//
// Purpose: counts startOfFrame ticks while a timed phase is active and flags
//          the tick that reaches the terminal count.
// Ports:
//   clk, resetN  clock, asynchronous active-low reset
//   clear        hold the count at 0
//   tick         one-cycle frame pulse
//   freeze       ignore ticks, keep the count
//   terminal     frame count at which done fires
//   count        frames counted since the last clear
//   done         high on the tick that brings count to terminal (count wraps to 0)
module frame_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             tick,
  input  logic             freeze,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_inc;
  logic             w_step;

  assign w_step = tick & ~freeze & ~clear;
  assign w_inc  = r_count + 1'b1;
  // Combinational so the phase FSM can leave on the same edge that samples the tick.
  assign done   = w_step & (w_inc == terminal);
  assign count  = r_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear || done) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= w_inc;
    end
  end

endmodule

// File: rtl/game_phase_controller.sv
// rtl/game_phase_controller.sv - game phase sequencer: lives, level, flashes and background override
//
// Purpose: runs IDLE/PLAY/HIT/LEVEL_UP/GAME_OVER, tracks lives and level, gates
//          movement with game_enable and drives the background colour override.
// Optional: define GAME_PHASE_PAUSE_EN to add the PAUSED phase on pause_key.
// Ports:
//   clk, resetN       clock, asynchronous active-low reset
//   startOfFrame      one-cycle pulse per video frame
//   start_key         debounced start key (level)
//   pause_key         debounced pause key (level), GAME_PHASE_PAUSE_EN only
//   player_hit        one-cycle pulse from collision logic
//   enemies_cleared   one-cycle pulse when the last enemy dies
//   phase             current phase_t encoding
//   game_enable       movement/shooting allowed
//   lives, level      remaining lives, current level
//   bg_override_en    background drawer shows bg_override_RGB
//   bg_override_RGB   override colour
module game_phase_controller
  import game_pkg::*;
#(
  parameter int                   RGB_WIDTH       = 8,
  parameter int                   LIVES_WIDTH     = 3,
  parameter int                   START_LIVES     = 3,
  parameter int                   LEVEL_WIDTH     = 4,
  parameter int                   FLASH_FRAMES    = DEF_FLASH_FRAMES,
  parameter int                   FLASH_PERIOD    = DEF_FLASH_PERIOD,
  parameter int                   GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES,
  parameter logic [RGB_WIDTH-1:0] HIT_COLOR       = RGB_WIDTH'(DEF_HIT_COLOR),
  parameter logic [RGB_WIDTH-1:0] LEVEL_COLOR     = RGB_WIDTH'(DEF_LEVEL_COLOR),
  parameter logic [RGB_WIDTH-1:0] GAMEOVER_COLOR  = RGB_WIDTH'(DEF_GAMEOVER_COLOR)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   start_key,
  input  logic                   pause_key,
  input  logic                   player_hit,
  input  logic                   enemies_cleared,
  output logic [2:0]             phase,
  output logic                   game_enable,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   bg_override_en,
  output logic [RGB_WIDTH-1:0]   bg_override_RGB
);

  localparam int TW = $clog2(((FLASH_FRAMES > GAMEOVER_FRAMES) ? FLASH_FRAMES : GAMEOVER_FRAMES) + 1);
  localparam logic [TW-1:0] FLASH_T    = TW'(FLASH_FRAMES);
  localparam logic [TW-1:0] GAMEOVER_T = TW'(GAMEOVER_FRAMES);
  localparam logic [TW-1:0] PERIOD_T   = TW'(FLASH_PERIOD);

  phase_t                 r_state;
  logic                   r_game_enable;
  logic [LIVES_WIDTH-1:0] r_lives;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic                   r_bg_en;
  logic [RGB_WIDTH-1:0]   r_bg_rgb;
  // Holds "key was low last cycle"; cleared by reset so a key held through
  // reset must be released before it can register a press.
  logic                   r_start_rel;

  logic          w_start_press;
  logic          w_pause_press;
  logic          w_clear;
  logic          w_freeze;
  logic          w_done;
  logic [TW-1:0] w_terminal;
  logic [TW-1:0] w_count;
  logic [TW-1:0] w_count_ahead;
  logic [TW-1:0] w_flash_idx;
  logic          w_lit;

  assign w_start_press = start_key & r_start_rel;

`ifdef GAME_PHASE_PAUSE_EN
  logic r_pause_rel;

  assign w_pause_press = pause_key & r_pause_rel;
  assign w_freeze      = (r_state == PAUSED);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pause_rel <= 1'b0;
    end else begin
      r_pause_rel <= ~pause_key;
    end
  end
`else
  logic w_unused_pause;

  assign w_unused_pause = pause_key;
  assign w_pause_press  = 1'b0;
  assign w_freeze       = 1'b0;
`endif

  // Timed phases are only entered from IDLE/PLAY, where the timer is held at 0,
  // and the timer wraps to 0 on done, so every phase entry starts from 0.
  assign w_clear    = (r_state == IDLE) || (r_state == PLAY);
  assign w_terminal = (r_state == GAME_OVER) ? GAMEOVER_T : FLASH_T;

  frame_timer #(
    .WIDTH (TW)
  ) u_frame_timer (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (w_clear),
    .tick     (startOfFrame),
    .freeze   (w_freeze),
    .terminal (w_terminal),
    .count    (w_count),
    .done     (w_done)
  );

  // Flash state for the frame count the timer holds after this edge, so the
  // registered override changes on the same edge as the count.
  assign w_count_ahead = startOfFrame ? (w_count + 1'b1) : w_count;
  assign w_flash_idx   = w_count_ahead / PERIOD_T;
  assign w_lit         = ~w_flash_idx[0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_game_enable <= 1'b0;
      r_lives       <= '0;
      r_level       <= '0;
      r_bg_en       <= 1'b0;
      r_bg_rgb      <= '0;
      r_start_rel   <= 1'b0;
    end else begin
      r_start_rel <= ~start_key;
      case (r_state)
        IDLE: begin
          if (w_start_press) begin
            r_state       <= PLAY;
            r_lives       <= LIVES_WIDTH'(START_LIVES);
            r_level       <= LEVEL_WIDTH'(1);
            r_game_enable <= 1'b1;
          end
        end
        PLAY: begin
          // player_hit has priority; a simultaneous enemies_cleared is dropped.
          if (player_hit) begin
            r_game_enable <= 1'b0;
            r_bg_en       <= 1'b1;
            if (r_lives <= LIVES_WIDTH'(1)) begin
              r_state  <= GAME_OVER;
              r_lives  <= '0;
              r_bg_rgb <= GAMEOVER_COLOR;
            end else begin
              r_state  <= HIT;
              r_lives  <= r_lives - 1'b1;
              r_bg_rgb <= HIT_COLOR;
            end
          end else if (enemies_cleared) begin
            r_state       <= LEVEL_UP;
            r_game_enable <= 1'b0;
            r_bg_en       <= 1'b1;
            r_bg_rgb      <= LEVEL_COLOR;
            if (r_level != {LEVEL_WIDTH{1'b1}}) begin
              r_level <= r_level + 1'b1;
            end
          end else if (w_pause_press) begin
            r_state       <= PAUSED;
            r_game_enable <= 1'b0;
            r_bg_en       <= 1'b0;
          end
        end
        HIT, LEVEL_UP: begin
          if (w_done) begin
            r_state       <= PLAY;
            r_game_enable <= 1'b1;
            r_bg_en       <= 1'b0;
            r_bg_rgb      <= '0;
          end else begin
            r_bg_en <= w_lit;
          end
        end
        GAME_OVER: begin
          if (w_done) begin
            r_state  <= IDLE;
            r_level  <= '0;
            r_bg_en  <= 1'b0;
            r_bg_rgb <= '0;
          end
        end
        PAUSED: begin
          if (w_pause_press) begin
            r_state       <= PLAY;
            r_game_enable <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign phase           = r_state;
  assign game_enable     = r_game_enable;
  assign lives           = r_lives;
  assign level           = r_level;
  assign bg_override_en  = r_bg_en;
  assign bg_override_RGB = r_bg_rgb;

endmodule

// File: tb/tb_game_phase_controller.sv
// tb/tb_game_phase_controller.sv - self-checking bench for game_phase_controller
module tb_game_phase_controller;

`ifdef GAME_PHASE_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       start_key = 1'b0;
  logic       pause_key = 1'b0;
  logic       player_hit = 1'b0;
  logic       enemies_cleared = 1'b0;
  logic [2:0] phase;
  logic       game_enable;
  logic [2:0] lives;
  logic [3:0] level;
  logic       bg_override_en;
  logic [7:0] bg_override_RGB;

  int errors = 0;
  int checks = 0;

  // Reference model: phase number, lives, level and frames seen since phase entry.
  int m_phase, m_lives, m_level, m_frames;
  bit m_prev_start, m_prev_pause;

  always #5 clk = ~clk;

  game_phase_controller dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .start_key       (start_key),
    .pause_key       (pause_key),
    .player_hit      (player_hit),
    .enemies_cleared (enemies_cleared),
    .phase           (phase),
    .game_enable     (game_enable),
    .lives           (lives),
    .level           (level),
    .bg_override_en  (bg_override_en),
    .bg_override_RGB (bg_override_RGB)
  );

  task automatic model_reset();
    m_phase = 0; m_lives = 0; m_level = 0; m_frames = 0;
    m_prev_start = 1'b1;  // a key held through reset is not a press
    m_prev_pause = 1'b1;
  endtask

  task automatic model_step(input bit s, input bit p, input bit h, input bit c, input bit f);
    bit sp, pp;
    sp = s && !m_prev_start;
    pp = p && !m_prev_pause;
    m_prev_start = s;
    m_prev_pause = p;
    case (m_phase)
      0: if (sp) begin m_phase = 1; m_lives = 3; m_level = 1; end
      1: begin
        if (h) begin
          m_frames = 0;
          if (m_lives == 1) begin m_lives = 0; m_phase = 4; end
          else begin m_lives = m_lives - 1; m_phase = 2; end
        end else if (c) begin
          m_frames = 0;
          if (m_level < 15) m_level = m_level + 1;
          m_phase = 3;
        end else if (PAUSE_ON && pp) begin
          m_phase = 5;
        end
      end
      2, 3: if (f) begin m_frames++; if (m_frames == 30) m_phase = 1; end
      4: if (f) begin m_frames++; if (m_frames == 120) begin m_phase = 0; m_level = 0; end end
      5: if (pp) m_phase = 1;
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [19:0] exp_vec();
    logic       ge, bg;
    logic [7:0] rgb;
    ge  = (m_phase == 1);
    bg  = 1'b0;
    rgb = 8'h00;
    if (m_phase == 2 || m_phase == 3) begin
      bg  = ((m_frames / 6) % 2) == 0;
      rgb = (m_phase == 2) ? 8'hE0 : 8'h1C;
    end else if (m_phase == 4) begin
      bg  = 1'b1;
      rgb = 8'h40;
    end
    return {3'(m_phase), ge, 3'(m_lives), 4'(m_level), bg, rgb};
  endfunction

  task automatic step(input bit s, input bit p, input bit h, input bit c, input bit f);
    start_key = s; pause_key = p; player_hit = h; enemies_cleared = c; startOfFrame = f;
    @(posedge clk);
    model_step(s, p, h, c, f);
    @(negedge clk);
  endtask

  task automatic send_frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; start_key = 1'b1; pause_key = 1'b0;
    player_hit = 1'b0; enemies_cleared = 1'b0; startOfFrame = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({phase, game_enable, lives, level, bg_override_en, bg_override_RGB} !== 20'h0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=00000", {phase, game_enable, lives, level, bg_override_en, bg_override_RGB});
    end
    resetN = 1'b1;
    repeat (4) step(1, 0, 0, 0, 0);
    checks++;
    if (phase !== 3'd0) begin errors++; $display("FAIL held_start_ignored phase=%0d exp=0", phase); end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL start_phase got=%0d exp=1", phase); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL start_lives got=%0d exp=3", lives); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL start_level got=%0d exp=1", level); end
    checks++; if (game_enable !== 1'b1) begin errors++; $display("FAIL start_enable got=%0b exp=1", game_enable); end
  endtask

  task automatic test_hit_flash();
    step(0, 0, 1, 0, 0);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL hit_phase got=%0d exp=2", phase); end
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL hit_lives got=%0d exp=2", lives); end
    checks++; if (game_enable !== 1'b0) begin errors++; $display("FAIL hit_enable got=%0b exp=0", game_enable); end
    checks++;
    if (bg_override_en !== 1'b1 || bg_override_RGB !== 8'hE0) begin
      errors++; $display("FAIL hit_entry_bg en=%0b rgb=%h exp en=1 rgb=e0", bg_override_en, bg_override_RGB);
    end
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0, 0, 1);
      if (k < 30) begin
        checks++;
        if (bg_override_en !== (((k / 6) % 2) == 0)) begin
          errors++; $display("FAIL hit_flash frame=%0d got=%0b", k, bg_override_en);
        end
      end
      if (k == 15) step(0, 0, 1, 1, 0);  // ignored outside PLAY
      else step(0, 0, 0, 0, 0);
    end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL hit_return got=%0d exp=1", phase); end
    checks++;
    if (lives !== 3'd2 || level !== 4'd1) begin
      errors++; $display("FAIL hit_ignored_events lives=%0d level=%0d exp 2 1", lives, level);
    end
  endtask

  task automatic test_level_saturate();
    for (int n = 0; n < 14; n++) begin
      step(0, 0, 0, 1, 0);
      send_frames(30);
    end
    checks++; if (level !== 4'd15 || phase !== 3'd1) begin errors++; $display("FAIL level_climb level=%0d phase=%0d exp 15 1", level, phase); end
    step(0, 0, 0, 1, 0);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL lvl_phase got=%0d exp=3", phase); end
    checks++; if (level !== 4'd15) begin errors++; $display("FAIL lvl_saturate got=%0d exp=15", level); end
    checks++;
    if (bg_override_RGB !== 8'h1C || bg_override_en !== 1'b1) begin
      errors++; $display("FAIL lvl_colour rgb=%h en=%0b exp rgb=1c en=1", bg_override_RGB, bg_override_en);
    end
    send_frames(29);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL lvl_early_exit got=%0d exp=3", phase); end
    send_frames(1);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL lvl_return got=%0d exp=1", phase); end
  endtask

  task automatic test_simul_gameover();
    step(0, 0, 1, 0, 0);
    send_frames(30);
    checks++; if (lives !== 3'd1 || phase !== 3'd1) begin errors++; $display("FAIL pre_go lives=%0d phase=%0d exp 1 1", lives, phase); end
    step(0, 0, 1, 1, 0);
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL go_phase got=%0d exp=4", phase); end
    checks++; if (lives !== 3'd0) begin errors++; $display("FAIL go_lives got=%0d exp=0", lives); end
    checks++; if (level !== 4'd15) begin errors++; $display("FAIL go_level_kept got=%0d exp=15", level); end
    checks++;
    if (bg_override_en !== 1'b1 || bg_override_RGB !== 8'h40) begin
      errors++; $display("FAIL go_colour en=%0b rgb=%h exp en=1 rgb=40", bg_override_en, bg_override_RGB);
    end
    send_frames(119);
    checks++;
    if (phase !== 3'd4 || bg_override_en !== 1'b1) begin
      errors++; $display("FAIL go_hold phase=%0d en=%0b exp 4 1", phase, bg_override_en);
    end
    send_frames(1);
    checks++;
    if (phase !== 3'd0 || level !== 4'd0 || lives !== 3'd0 || game_enable !== 1'b0) begin
      errors++; $display("FAIL go_to_idle phase=%0d level=%0d lives=%0d en=%0b exp 0 0 0 0", phase, level, lives, game_enable);
    end
  endtask

  task automatic test_reset_mid_hit();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    send_frames(10);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL mid_hit_setup got=%0d exp=2", phase); end
    resetN = 1'b0;
    #1;
    checks++;
    if ({phase, game_enable, lives, level, bg_override_en, bg_override_RGB} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=00000", {phase, game_enable, lives, level, bg_override_en, bg_override_RGB});
    end
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++;
    if (phase !== 3'd1 || lives !== 3'd3 || level !== 4'd1) begin
      errors++; $display("FAIL fresh_start phase=%0d lives=%0d level=%0d exp 1 3 1", phase, lives, level);
    end
    step(0, 0, 1, 0, 0);
    send_frames(29);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL fresh_timer got=%0d exp=2", phase); end
    send_frames(1);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL fresh_timer_end got=%0d exp=1", phase); end
  endtask

`ifdef GAME_PHASE_PAUSE_EN
  task automatic test_pause();
    step(0, 1, 0, 0, 0);
    checks++;
    if (phase !== 3'd5 || game_enable !== 1'b0 || bg_override_en !== 1'b0) begin
      errors++; $display("FAIL pause_enter phase=%0d en=%0b bg=%0b exp 5 0 0", phase, game_enable, bg_override_en);
    end
    step(0, 0, 1, 1, 0);
    send_frames(50);
    checks++;
    if (phase !== 3'd5 || lives !== 3'd2 || level !== 4'd1) begin
      errors++; $display("FAIL pause_hold phase=%0d lives=%0d level=%0d exp 5 2 1", phase, lives, level);
    end
    step(0, 1, 0, 0, 0);
    checks++;
    if (phase !== 3'd1 || game_enable !== 1'b1) begin
      errors++; $display("FAIL pause_exit phase=%0d en=%0b exp 1 1", phase, game_enable);
    end
  endtask
`endif

  task automatic test_random();
    logic        s;
    logic [19:0] got, exp;
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      step(s, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      got = {phase, game_enable, lives, level, bg_override_en, bg_override_RGB};
      exp = exp_vec();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_flash();
    test_level_saturate();
    test_simul_gameover();
    test_reset_mid_hit();
`ifdef GAME_PHASE_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
